serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 162 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor -- digit-serial subtractor, diff = a - b - bin.
//
// One DIGIT-bit subtract slice is reused over N = WIDTH/DIGIT clocks. The
// LSB digit is processed first. A registered borrow links each digit to the
// next. A start/done handshake wraps the operation.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits per clock, must divide WIDTH
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only while ready=1
//   a, b   minuend / subtrahend, captured on the accepted start
//   bin    borrow-in, captured on the accepted start
//   ready  can accept start (IDLE or DONE)
//   busy   computation in progress (RUN)
//   done   one-cycle pulse, result valid
//   diff   difference, held until the next accepted start
//   bout   final borrow-out, held with diff
//   ovf    signed overflow, held with diff
//
// Build option
//   SERIAL_SUB_OVF_EN  when defined, ovf is computed. When undefined, ovf is
//                      tied low and the port remains.

// One DIGIT-bit subtract slice: {bout, d} = a - b - bin.
module serial_sub_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);
  logic [DIGIT:0] r;

  // The DIGIT+1 bit result goes negative exactly when a borrow occurs, so
  // the top bit is the borrow-out.
  assign r    = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
  assign d    = r[DIGIT-1:0];
  assign bout = r[DIGIT];
endmodule

module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh, b_sh;     // operands, shifted right one digit per RUN cycle
  logic [WIDTH-1:0] diff_q, diff_nx;
  logic             borrow_q, bout_q;
  logic [DIGIT-1:0] dig;
  logic             borrow_nx;
  logic             last, accept;

  assign last   = (cnt_q == CW'(N - 1));
  // ready depends on state only, so accept is simply ready & start.
  assign accept = start && (state_q != RUN);

  serial_sub_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .bin  (borrow_q),
    .d    (dig),
    .bout (borrow_nx)
  );

  // diff fills from the top. After N digits the first digit sits at the LSB.
  if (DIGIT == WIDTH) begin : g_single
    assign diff_nx = dig;
  end else begin : g_multi
    assign diff_nx = {dig, diff_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sh     <= a;
        b_sh     <= b;
        borrow_q <= bin;
        cnt_q    <= '0;
      end else if (state_q == RUN) begin
        a_sh     <= a_sh >> DIGIT;
        b_sh     <= b_sh >> DIGIT;
        borrow_q <= borrow_nx;
        diff_q   <= diff_nx;
        cnt_q    <= cnt_q + 1'b1;
        if (last) bout_q <= borrow_nx;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // The operand MSBs are shifted out of a_sh/b_sh, so keep copies for the
  // overflow term. The result MSB is the top bit of the last digit.
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state_q == RUN && last) begin
      ovf_q <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ dig[DIGIT-1]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign ready = (state_q != RUN);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign bout  = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor. Five instances share one stimulus stream:
// inst 0 is WIDTH=8/DIGIT=1, and insts 1..4 are WIDTH=16 with DIGIT 1/2/4/16.
// Each instance has an arithmetic reference model. The model counts N edges
// after an accepted start, then expects a - b - bin.
module tb_serial_subtractor;
  localparam int NI = 5;

`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, bin = 1'b0;
  logic [15:0] a = '0, b = '0;
  wire  [NI-1:0]       ready_v, busy_v, done_v, bout_v, ovf_v;
  wire  [NI-1:0][15:0] diff_v;
  int pass_cnt = 0, total = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h at %0t", name, inst, act, exp, $time);
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g == 0) ? 8 : 16;
    localparam int D = (g <= 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 4 : 16;
    localparam int N = W / D;

    wire [W-1:0] dw;

    serial_subtractor #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .a(a[W-1:0]), .b(b[W-1:0]), .bin(bin),
      .ready(ready_v[g]), .busy(busy_v[g]), .done(done_v[g]),
      .diff(dw), .bout(bout_v[g]), .ovf(ovf_v[g])
    );
    assign diff_v[g] = 16'(dw);

    // Reference model. m_left counts the edges left until the result is due.
    int         m_left = 0;
    logic [W-1:0] m_diff = '0, pa = '0, pb = '0;
    logic       m_bout = 1'b0, m_ovf = 1'b0, m_done = 1'b0, pbin = 1'b0;

    always @(posedge clk) begin
      logic [W:0] full;
      int res;
      m_done = 1'b0;
      if (rst) begin
        m_left = 0; m_diff = '0; m_bout = 1'b0; m_ovf = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          full   = {1'b0, pa} - {1'b0, pb} - (W+1)'(pbin);
          m_diff = full[W-1:0];
          m_bout = full[W];
          res    = int'($signed(pa)) - int'($signed(pb)) - int'(pbin);
          m_ovf  = OVF_EN && ((res > (2**(W-1)) - 1) || (res < -(2**(W-1))));
          m_done = 1'b1;
        end
      end else if (start) begin
        pa = a[W-1:0]; pb = b[W-1:0]; pbin = bin; m_left = N;
      end
    end

    always @(negedge clk) begin
      chk("ready", g, 16'(ready_v[g]), 16'(m_left == 0));
      chk("busy",  g, 16'(busy_v[g]),  16'(m_left > 0));
      chk("done",  g, 16'(done_v[g]),  16'(m_done));
      if (m_left == 0) begin
        chk("diff", g, diff_v[g],        16'(m_diff));
        chk("bout", g, 16'(bout_v[g]),   16'(m_bout));
        chk("ovf",  g, 16'(ovf_v[g]),    16'(m_ovf));
      end
    end
  end

  // Issue one start pulse. On return, edge E0 has just accepted it.
  // The operands are then scrambled to show they were captured.
  task automatic go(input logic [15:0] ta, input logic [15:0] tbv, input logic tbin);
    @(posedge clk); #1 a = ta; b = tbv; bin = tbin; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
  endtask

  // Count edges from E0 (inclusive) until done is seen on instance inst.
  task automatic wait_done(input int inst, output int edges);
    edges = 1;
    while (!done_v[inst] && edges < 64) begin
      @(posedge clk); #1; edges++;
    end
    if (!done_v[inst]) begin
      total++;
      $display("FAIL wait_done[%0d]: done not seen within %0d edges", inst, edges);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int e, nd;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 0, 16'(ready_v[0]), 16'd1);
    chk("rst_diff",  0, diff_v[0], 16'h0000);

    // Basic subtraction
    go(16'h0005, 16'h0003, 1'b0); wait_done(0, e);
    chk("lat_basic", 0, 16'(e), 16'd9);
    chk("diff_basic", 0, diff_v[0], 16'h0002);
    chk("bout_basic", 0, 16'(bout_v[0]), 16'd0);
    chk("ovf_basic",  0, 16'(ovf_v[0]), 16'd0);
    idle(20);

    // Wrap with borrow-out
    go(16'h0000, 16'h0001, 1'b0); wait_done(0, e);
    chk("diff_wrap", 0, diff_v[0], 16'h00FF);
    chk("bout_wrap", 0, 16'(bout_v[0]), 16'd1);
    chk("ovf_wrap",  0, 16'(ovf_v[0]), 16'd0);
    idle(20);

    // Borrow-in causing signed overflow
    go(16'h0080, 16'h0000, 1'b1); wait_done(0, e);
    chk("diff_bin", 0, diff_v[0], 16'h007F);
    chk("bout_bin", 0, 16'(bout_v[0]), 16'd0);
    chk("ovf_bin",  0, 16'(ovf_v[0]), 16'(OVF_EN));
    idle(20);

    // A start pulse during RUN is ignored
    go(16'h005A, 16'h0033, 1'b0);
    repeat (3) @(posedge clk);
    #1 a = 16'h0011; b = 16'h0022; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(0, e);
    chk("diff_ignore", 0, diff_v[0], 16'h0027);
    chk("bout_ignore", 0, 16'(bout_v[0]), 16'd0);

    // Back-to-back: start is held in the DONE cycle
    a = 16'h0010; b = 16'h0020; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(0, e);
    chk("lat_b2b",  0, 16'(e), 16'd9);
    chk("diff_b2b", 0, diff_v[0], 16'h00F0);
    chk("bout_b2b", 0, 16'(bout_v[0]), 16'd1);
    idle(20);

    // Reset at digit 4 aborts without a done pulse
    go(16'h0077, 16'h0011, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_ready", 0, 16'(ready_v[0]), 16'd1);
    chk("abort_busy",  0, 16'(busy_v[0]),  16'd0);
    chk("abort_diff",  0, diff_v[0], 16'h0000);
    nd = 0;
    repeat (12) begin @(posedge clk); #1; if (done_v[0]) nd++; end
    chk("abort_nodone", 0, 16'(nd), 16'd0);

    // Digit sweep, 16-bit with DIGIT=4
    go(16'h1234, 16'h0235, 1'b0); wait_done(3, e);
    chk("lat_d4",  3, 16'(e), 16'd5);
    chk("diff_d4", 3, diff_v[3], 16'h0FFF);
    chk("bout_d4", 3, 16'(bout_v[3]), 16'd0);
    idle(20);
    for (int i = 1; i < NI; i++) chk("diff_sweep", i, diff_v[i], 16'h0FFF);
    chk("diff_sweep8", 0, diff_v[0], 16'h00FF);
    chk("bout_sweep8", 0, 16'(bout_v[0]), 16'd1);

    // Random traffic. The per-instance models check every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0: a = 16'h0000;
        1: a = 16'hFFFF;
        2: a = 16'h8000;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: b = 16'h0000;
        1: b = 16'hFFFF;
        2: b = 16'h7FFF;
        default: b = 16'($urandom);
      endcase
      bin = 1'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    #0 rst = 1'b0; start = 1'b0;
    idle(20);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
